// File: rtl/cpu_inta_sequencer_pkg.sv
// Shared interrupt-acknowledge definitions: FSM states, vector width and
// default pulse timing for the CPU-side INTA sequencer.
package cpu_inta_sequencer_pkg;

    localparam int unsigned VEC_W                = 8;
    localparam int unsigned DEFAULT_PULSE_CYCLES = 2;
    localparam int unsigned DEFAULT_GAP_CYCLES   = 2;

    typedef enum logic [2:0] {
        IDLE,
        ACK1,
        GAP,
        ACK2,
        HOLD
    } inta_state_t;

    // Width of a down-counter that must hold max(a,b)-1, never below 1 bit
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        cnt_width = (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/inta_pulse_timer.sv
// Loadable saturating down-counter that times INTA pulse and gap phases.
module inta_pulse_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/cpu_inta_sequencer.sv
// CPU-side interrupt-acknowledge sequencer: issues two INTA low pulses on an
// enabled INT request, captures the vector on the second, and hands it to the core.
module cpu_inta_sequencer
    import cpu_inta_sequencer_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
    parameter int unsigned GAP_CYCLES   = DEFAULT_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             INT,
    input  logic             int_enable,
    input  logic [VEC_W-1:0] data_bus,
    output logic             INTA,
    output logic [VEC_W-1:0] vector,
    output logic             vector_valid,
    input  logic             vector_ready,
    output logic             busy
);

    localparam int unsigned CNT_W = cnt_width(PULSE_CYCLES, GAP_CYCLES);

    inta_state_t      state;
    inta_state_t      state_next;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic             expired;
    logic             capture;

    inta_pulse_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_value(load_value),
        .expired   (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; INT and int_enable only matter in IDLE so a started sequence always completes
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        load       = 1'b0;
        load_value = CNT_W'(PULSE_CYCLES - 1);
        case (state)
            IDLE: if (INT && int_enable) state_next = ACK1;
            ACK1: if (expired) state_next = GAP;
            GAP:  if (expired) state_next = ACK2;
            ACK2: begin
                if (expired) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            HOLD: if (vector_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state_next != state) begin
            load = (state_next == ACK1) || (state_next == GAP) || (state_next == ACK2);
            if (state_next == GAP) begin
                load_value = CNT_W'(GAP_CYCLES - 1);
            end
        end
    end

    // Outputs registered from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            INTA         <= 1'b1;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
            vector       <= '0;
        end else begin
            INTA         <= !((state_next == ACK1) || (state_next == ACK2));
            vector_valid <= (state_next == HOLD);
            busy         <= (state_next != IDLE);
            if (capture) begin
                vector <= data_bus;
            end
        end
    end

endmodule

// File: tb/tb_cpu_inta_sequencer.sv
// Directed self-checking bench for cpu_inta_sequencer (default and 1/1 timing).
module tb_cpu_inta_sequencer;

    logic       clk;
    int         total;
    int         bad;

    // default-timing instance
    logic       reset, int_req, int_enable, vector_ready;
    logic [7:0] data_bus;
    logic       inta, vector_valid, busy;
    logic [7:0] vector;

    // PULSE_CYCLES=1, GAP_CYCLES=1 instance
    logic       reset1, int_req1, int_enable1, vector_ready1;
    logic [7:0] data_bus1;
    logic       inta1, vector_valid1, busy1;
    logic [7:0] vector1;

    cpu_inta_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .INT         (int_req),
        .int_enable  (int_enable),
        .data_bus    (data_bus),
        .INTA        (inta),
        .vector      (vector),
        .vector_valid(vector_valid),
        .vector_ready(vector_ready),
        .busy        (busy)
    );

    cpu_inta_sequencer #(
        .PULSE_CYCLES(1),
        .GAP_CYCLES  (1)
    ) dut1 (
        .clk         (clk),
        .reset       (reset1),
        .INT         (int_req1),
        .int_enable  (int_enable1),
        .data_bus    (data_bus1),
        .INTA        (inta1),
        .vector      (vector1),
        .vector_valid(vector_valid1),
        .vector_ready(vector_ready1),
        .busy        (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled and inputs driven 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        vector_ready = 1'b1;
        for (int k = 0; k < 20 && busy; k++) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL drain_timeout busy=%b want 0", busy);
        end
        vector_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; reset1 = 1'b1;
        tick(); tick();
        reset = 1'b0; reset1 = 1'b0;
        total++; if (inta !== 1'b1) begin bad++; $display("FAIL reset_inta got=%b want 1", inta); end
        total++; if (vector !== 8'h00) begin bad++; $display("FAIL reset_vector got=%h want 00", vector); end
        total++; if (vector_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want 0", vector_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want 0", busy); end
        total++; if (inta1 !== 1'b1) begin bad++; $display("FAIL reset_inta1 got=%b want 1", inta1); end
    endtask

    task automatic test_basic();
        logic [6:0] exp_inta;
        exp_inta = 7'b1001100;   // after edges n..n+6: 0,0,1,1,0,0,1
        int_enable = 1'b1;
        int_req    = 1'b1;
        data_bus   = 8'h0B;
        for (int i = 0; i < 7; i++) begin
            tick();
            int_req = 1'b0;
            total++;
            if (inta !== exp_inta[i]) begin
                bad++; $display("FAIL basic_inta step=%0d got=%b want %b", i, inta, exp_inta[i]);
            end
            total++;
            if (vector_valid !== (i == 6)) begin
                bad++; $display("FAIL basic_valid step=%0d got=%b want %b", i, vector_valid, (i == 6));
            end
            total++;
            if (busy !== 1'b1) begin
                bad++; $display("FAIL basic_busy step=%0d got=%b want 1", i, busy);
            end
        end
        total++; if (vector !== 8'h0B) begin bad++; $display("FAIL basic_vector got=%h want 0b", vector); end
        vector_ready = 1'b1;
        tick();
        vector_ready = 1'b0;
        total++; if (vector_valid !== 1'b0) begin bad++; $display("FAIL basic_handshake_valid got=%b want 0", vector_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_handshake_busy got=%b want 0", busy); end
        total++; if (vector !== 8'h0B) begin bad++; $display("FAIL basic_vector_hold got=%h want 0b", vector); end
    endtask

    task automatic test_disabled();
        int_enable = 1'b0;
        int_req    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (inta !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL disabled_idle step=%0d inta=%b busy=%b want 1/0", i, inta, busy);
            end
        end
        int_enable = 1'b1;
        tick();
        int_req = 1'b0;
        total++; if (inta !== 1'b0) begin bad++; $display("FAIL enable_start_inta got=%b want 0", inta); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL enable_start_busy got=%b want 1", busy); end
        drain();
    endtask

    task automatic test_int_drop_gap();
        int_enable = 1'b1;
        int_req    = 1'b1;
        data_bus   = 8'h00;
        tick(); tick(); tick();   // edges n, n+1, n+2: now in GAP
        total++; if (inta !== 1'b1) begin bad++; $display("FAIL gap_inta got=%b want 1", inta); end
        int_req    = 1'b0;
        int_enable = 1'b0;
        tick(); tick();           // edge n+4: second pulse begins
        total++; if (inta !== 1'b0) begin bad++; $display("FAIL drop_second_pulse got=%b want 0", inta); end
        data_bus = 8'h0F;
        tick(); tick();           // edge n+6: capture
        total++; if (vector_valid !== 1'b1) begin bad++; $display("FAIL drop_valid got=%b want 1", vector_valid); end
        total++; if (vector !== 8'h0F) begin bad++; $display("FAIL drop_vector got=%h want 0f", vector); end
        drain();
    endtask

    task automatic test_hold_stall();
        int_enable   = 1'b1;
        int_req      = 1'b1;
        data_bus     = 8'h5A;
        vector_ready = 1'b1;      // ignored outside HOLD
        tick();
        vector_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        total++; if (vector !== 8'h5A) begin bad++; $display("FAIL stall_capture got=%h want 5a", vector); end
        data_bus = 8'h33;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (vector_valid !== 1'b1 || vector !== 8'h5A) begin
                bad++; $display("FAIL stall_hold step=%0d valid=%b vector=%h want 1/5a", i, vector_valid, vector);
            end
        end
        vector_ready = 1'b1;
        tick();                   // handshake edge m, INT still high
        vector_ready = 1'b0;
        total++; if (vector_valid !== 1'b0) begin bad++; $display("FAIL stall_release_valid got=%b want 0", vector_valid); end
        total++; if (busy !== 1'b0 || inta !== 1'b1) begin bad++; $display("FAIL stall_idle busy=%b inta=%b want 0/1", busy, inta); end
        tick();                   // edge m+1 starts the next ACK1
        int_req = 1'b0;
        total++; if (inta !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL reissue inta=%b busy=%b want 0/1", inta, busy); end
        drain();
    endtask

    task automatic test_reset_mid();
        int_enable = 1'b1;
        int_req    = 1'b1;
        data_bus   = 8'hA5;
        tick();
        int_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();   // edge n+4: in ACK2
        total++; if (inta !== 1'b0) begin bad++; $display("FAIL mid_ack2_inta got=%b want 0", inta); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (inta !== 1'b1) begin bad++; $display("FAIL mid_reset_inta got=%b want 1", inta); end
        total++; if (vector_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b want 0", vector_valid); end
        total++; if (vector !== 8'h00) begin bad++; $display("FAIL mid_reset_vector got=%h want 00", vector); end
        tick(); tick();
        total++; if (busy !== 1'b0 || vector_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_idle busy=%b valid=%b want 0/0", busy, vector_valid); end
    endtask

    task automatic test_fast_timing();
        logic [3:0] exp_inta;
        exp_inta      = 4'b1010;  // after edges n..n+3: 0,1,0,1
        int_enable1   = 1'b1;
        int_req1      = 1'b1;
        data_bus1     = 8'hFF;
        vector_ready1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            int_req1 = 1'b0;
            total++;
            if (inta1 !== exp_inta[i] || vector_valid1 !== (i == 3)) begin
                bad++; $display("FAIL fast_step=%0d inta=%b valid=%b want %b/%b", i, inta1, vector_valid1, exp_inta[i], (i == 3));
            end
        end
        total++; if (vector1 !== 8'hFF) begin bad++; $display("FAIL fast_vector got=%h want ff", vector1); end
        vector_ready1 = 1'b1;
        tick();
        vector_ready1 = 1'b0;
        total++; if (vector_valid1 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL fast_handshake valid=%b busy=%b want 0/0", vector_valid1, busy1); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; int_req = 1'b0; int_enable = 1'b0; vector_ready = 1'b0; data_bus = 8'h00;
        reset1 = 1'b0; int_req1 = 1'b0; int_enable1 = 1'b0; vector_ready1 = 1'b0; data_bus1 = 8'h00;
        #1;
        test_reset();
        test_basic();
        test_disabled();
        test_int_drop_gap();
        test_hold_stall();
        test_reset_mid();
        test_fast_timing();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
